// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and a small signedness helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output start, op, srca, srcb, cancel,
    input  busy, done, hi, lo, divzero
  );

  modport slave (
    input  start, op, srca, srcb, cancel,
    output busy, done, hi, lo, divzero
  );

endinterface

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes going in, and sign
// correction of the unsigned iteration result coming out.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e                op,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag,
  output logic               a_neg,
  output logic               b_neg,
  input  op_e                fix_op,
  input  logic               fix_a_neg,
  input  logic               fix_b_neg,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   fix_hi,
  output logic [WIDTH-1:0]   fix_lo
);

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   raw_hi;
  logic [WIDTH-1:0]   raw_lo;
  logic               quo_neg;

  always_comb begin
    a_neg = is_signed_op(op) && srca[WIDTH-1];
    b_neg = is_signed_op(op) && srcb[WIDTH-1];
    a_mag = a_neg ? (-srca) : srca;
    b_mag = b_neg ? (-srcb) : srcb;
  end

  // Remainder takes the dividend's sign; quotient and product take the xor.
  always_comb begin
    raw_hi     = raw[2*WIDTH-1:WIDTH];
    raw_lo     = raw[WIDTH-1:0];
    quo_neg    = fix_a_neg ^ fix_b_neg;
    prod_fixed = quo_neg ? (-raw) : raw;
    if (fix_op[1]) begin
      fix_hi = fix_a_neg ? (-raw_hi) : raw_hi;
      fix_lo = quo_neg ? (-raw_lo) : raw_lo;
    end else begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with hi/lo results held until the next completion.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e             state;
  state_e             state_next;
  op_e                op_q;
  logic [WIDTH-1:0]   srca_q;
  logic [WIDTH-1:0]   b_mag_q;
  logic               a_neg_q;
  logic               b_neg_q;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_step;
  logic [CW-1:0]      count;
  logic               accept;
  logic               finish;
  logic               zero_div;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               divzero_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op        (bus.op),
    .srca      (bus.srca),
    .srcb      (bus.srcb),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .fix_op    (op_q),
    .fix_a_neg (a_neg_q),
    .fix_b_neg (b_neg_q),
    .raw       (acc_step[2*WIDTH-1:0]),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  // acc is {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    add_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, b_mag_q} : '0);
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_mag_q};
    if (state == MUL) begin
      acc_step = {add_sum, acc[WIDTH-1:0]} >> 1;
    end else if (rem_diff[WIDTH]) begin
      acc_step = {rem_shift, acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {rem_diff, acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    zero_div   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.start && !bus.cancel) begin
          accept     = 1'b1;
          state_next = bus.op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else if (count == LAST_ITER) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DIV: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else if (b_mag_q == '0) begin
          zero_div   = 1'b1;
          state_next = DONE;
        end else if (count == LAST_ITER) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q      <= OP_MULT;
      srca_q    <= '0;
      b_mag_q   <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      acc       <= '0;
      count     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.op;
        srca_q  <= bus.srca;
        b_mag_q <= b_mag;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        acc     <= {{(WIDTH + 1){1'b0}}, a_mag};
        count   <= '0;
      end else if ((state == MUL) || (state == DIV)) begin
        acc   <= acc_step;
        count <= count + 1'b1;
      end
      // Results only move on entry to DONE; a cancel leaves them untouched.
      if (finish) begin
        hi_q      <= fix_hi;
        lo_q      <= fix_lo;
        divzero_q <= 1'b0;
      end else if (zero_div) begin
        hi_q      <= srca_q;
        lo_q      <= '1;
        divzero_q <= 1'b1;
      end
    end
  end

  assign bus.busy    = (state == MUL) || (state == DIV);
  assign bus.done    = (state == DONE);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request so it is sampled at the next rising edge (cycle 0).
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts cycles from acceptance until done; done_cyc stays -1 on timeout.
  task automatic wait_done(output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = OP_MULT;
    bus.srca   = '0;
    bus.srcb   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h want 0", bus.lo); end
    checks++; if (bus.divzero !== 1'b0) begin errors++; $display("[TB] FAIL reset_divzero: got %b want 0", bus.divzero); end
    reset = 1'b1;
  endtask

  task automatic test_multu_max();
    int dc, bc;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(dc, bc);
    checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL multu_done_cycle: got %0d want 33", dc); end
    checks++; if (bc !== 32) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d want 32", bc); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo: got %h want 00000001", bus.lo); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL multu_done_pulse: got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL multu_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_signed();
    int dc, bc;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done(dc, bc);
    checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL mult_neg_cycle: got %0d want 33", dc); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_neg_hi: got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mult_neg_lo: got %h want ffffffeb", bus.lo); end
    issue(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done(dc, bc);
    checks++; if (bus.hi !== 32'h40000000) begin errors++; $display("[TB] FAIL mult_minmin_hi: got %h want 40000000", bus.hi); end
    checks++; if (bus.lo !== 32'h00000000) begin errors++; $display("[TB] FAIL mult_minmin_lo: got %h want 00000000", bus.lo); end
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(dc, bc);
    checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL div_neg_cycle: got %0d want 33", dc); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg_lo: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_neg_hi: got %h want ffffffff", bus.hi); end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(dc, bc);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo: got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("[TB] FAIL div_ovf_hi: got %h want 00000000", bus.hi); end
    checks++; if (bus.divzero !== 1'b0) begin errors++; $display("[TB] FAIL div_ovf_divzero: got %b want 0", bus.divzero); end
  endtask

  task automatic test_divzero();
    int dc, bc;
    issue(OP_DIVU, 32'h12345678, 32'h0);
    wait_done(dc, bc);
    checks++; if (dc !== 2) begin errors++; $display("[TB] FAIL divzero_cycle: got %0d want 2", dc); end
    checks++; if (bus.divzero !== 1'b1) begin errors++; $display("[TB] FAIL divzero_flag: got %b want 1", bus.divzero); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("[TB] FAIL divzero_hi: got %h want 12345678", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divzero_lo: got %h want ffffffff", bus.lo); end
    issue(OP_DIVU, 32'd9, 32'd4);
    wait_done(dc, bc);
    checks++; if (bus.divzero !== 1'b0) begin errors++; $display("[TB] FAIL divzero_clear: got %b want 0", bus.divzero); end
    checks++; if (bus.lo !== 32'd2 || bus.hi !== 32'd1) begin errors++; $display("[TB] FAIL divu_9_4: got hi=%h lo=%h want hi=1 lo=2", bus.hi, bus.lo); end
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    dc = -1;
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dc = c;
        break;
      end
      if (c == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.srca  = 32'd3;
        bus.srcb  = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL ignore_start_cycle: got %0d want 33", dc); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL ignore_start_lo: got %h want 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL ignore_start_hi: got %h want 00000002", bus.hi); end
    // New request raised during the DONE cycle itself.
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.srca  = 32'd6;
    bus.srcb  = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(dc, bc);
    checks++; if (dc !== 33) begin errors++; $display("[TB] FAIL b2b_cycle: got %0d want 33", dc); end
    checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL b2b_result: got hi=%h lo=%h want hi=0 lo=2a", bus.hi, bus.lo); end
  endtask

  task automatic test_cancel();
    int dc, bc, seen;
    issue(OP_MULTU, 32'd5, 32'd6);
    wait_done(dc, bc);
    issue(OP_MULT, 32'd1234, 32'd5678);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 10) bus.cancel = 1'b1;
      if (c == 11) begin
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_busy: got %b want 0", bus.busy); end
        bus.cancel = 1'b0;
      end
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL cancel_no_done: got %0d pulses want 0", seen); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd30) begin errors++; $display("[TB] FAIL cancel_hold: got hi=%h lo=%h want hi=0 lo=1e", bus.hi, bus.lo); end
    // Cancel in IDLE blocks a simultaneous start.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_blocks_start: got %b want 0", bus.busy); end
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dc, bc, seen;
    issue(OP_DIVU, 32'hABCD, 32'h0);
    wait_done(dc, bc);
    issue(OP_DIV, 32'd1000, 32'd3);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 10) begin
        reset = 1'b0;
      end else if (c == 11) begin
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ctrl: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.divzero !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_data: got hi=%h lo=%h dz=%b want 0", bus.hi, bus.lo, bus.divzero); end
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
      end else if (c == 12) begin
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_over_start: got %b want 0", bus.busy); end
        bus.start = 1'b0;
        reset     = 1'b1;
      end
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_done: got %0d pulses want 0", seen); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multu_max();
    test_signed();
    test_divzero();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
